sound_in: RTL and testbench

//  1-bit sound input (tape/line-in capture): the receive-side counterpart of the

---
 rtl/snd_pkg.sv | 8 +
 rtl/sound_in_fifo.sv | 102 ++++++++++
 rtl/sound_in.sv | 94 +++++++++
 tb/tb_sound_in.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared definitions for the 1-bit sound input path: sample width, saturation
// ceiling and the sample type passed between the decimator and its buffer.
package snd_pkg;
  localparam int SND_SAMPLE_W = 8;
  localparam logic [SND_SAMPLE_W-1:0] SND_SAT_MAX = 8'hFF;

  typedef logic [SND_SAMPLE_W-1:0] snd_sample_t;
endpackage

// File: rtl/sound_in_fifo.sv
// Sample buffer with sticky overrun. `define SND_IN_FIFO_EN selects a FIFO_DEPTH-entry
// circular buffer; otherwise a single holding register with a valid flag is built.
module sound_in_fifo
  import snd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  snd_sample_t i_din,
  input  logic        i_pop,
  input  logic        i_clr_ovr,
  output snd_sample_t o_dout,
  output logic        o_ready,
  output logic        o_overrun
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sound_in_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  snd_sample_t r_dout;
  logic        r_ovr;

`ifdef SND_IN_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W:0]   r_wr;
  logic [PTR_W:0]   r_rd;
  logic [PTR_W:0]   w_count;
  logic [PTR_W-1:0] w_rd_next_idx;
  logic             w_empty;
  logic             w_full;
  snd_sample_t      r_mem [FIFO_DEPTH];

  assign w_count       = r_wr - r_rd;
  assign w_empty       = (r_wr == r_rd);
  assign w_full        = (r_wr[PTR_W] != r_rd[PTR_W]) &&
                         (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);
  assign w_rd_next_idx = r_rd[PTR_W-1:0] + 1'b1;
  assign w_pop         = i_pop & ~w_empty;
  assign w_push        = i_push & (~w_full | w_pop);
  assign w_drop        = i_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[PTR_W-1:0]] <= i_din;
  end

  // dout is a show-ahead copy of the head, reloaded whenever the head moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_dout <= '0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        if (w_count != (PTR_W+1)'(1)) r_dout <= r_mem[w_rd_next_idx];
        else if (w_push)              r_dout <= i_din;
      end else if (w_empty && w_push) begin
        r_dout <= i_din;
      end
      if (w_drop)         r_ovr <= 1'b1;
      else if (i_clr_ovr) r_ovr <= 1'b0;
    end
  end

  assign o_ready = ~w_empty;
`else
  logic r_valid;

  assign w_pop  = i_pop & r_valid;
  assign w_push = i_push & (~r_valid | w_pop);
  assign w_drop = i_push & r_valid & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_push)     r_valid <= 1'b1;
      else if (w_pop) r_valid <= 1'b0;
      if (w_push) r_dout <= i_din;
      if (w_drop)         r_ovr <= 1'b1;
      else if (i_clr_ovr) r_ovr <= 1'b0;
    end
  end

  assign o_ready = r_valid;
`endif

  assign o_dout    = r_dout;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/sound_in.sv
// 1-bit sound input: synchronizes the comparator bit, returns it as sigma-delta
// feedback and integrates-and-dumps it into 8-bit samples (buffer depth via SND_IN_FIFO_EN).
module sound_in
  import snd_pkg::*;
#(
  parameter int DIV        = 8,
  parameter int WIN_LOG2   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pdm_in,
  output logic        fb_out,
  input  logic        sample_rd,
  input  logic        clr_ovr,
  output snd_sample_t dout,
  output logic        ready,
  output logic        overrun
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int SHIFT = (WIN_LOG2 < SND_SAMPLE_W) ? (SND_SAMPLE_W - WIN_LOG2) : 0;

  // Short windows are left-aligned so full scale still reaches 8 bits before clipping.
  function automatic snd_sample_t sat_sample(input logic [WIN_LOG2:0] sum);
    logic [WIN_LOG2+SND_SAMPLE_W:0] wide;
    wide = (WIN_LOG2+SND_SAMPLE_W+1)'(sum) << SHIFT;
    return (wide > (WIN_LOG2+SND_SAMPLE_W+1)'(SND_SAT_MAX)) ? SND_SAT_MAX
                                                             : wide[SND_SAMPLE_W-1:0];
  endfunction

  logic                r_sync1;
  logic                r_sync2;
  logic [DIV_W-1:0]    r_div;
  logic [WIN_LOG2-1:0] r_wcnt;
  logic [WIN_LOG2:0]   r_acc;
  logic                r_fb;
  logic                w_tick;
  logic                w_final;
  logic [WIN_LOG2:0]   w_sum;
  snd_sample_t         w_sample;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_final  = w_tick & (&r_wcnt);
  assign w_sum    = r_acc + {{WIN_LOG2{1'b0}}, r_sync2};
  assign w_sample = sat_sample(w_sum);

  // Stage: 2-FF synchronizer for the asynchronous comparator bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pdm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Stage: bit-tick divider, feedback bit, window counter and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_wcnt <= '0;
      r_acc  <= '0;
      r_fb   <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_fb   <= r_sync2;
        r_wcnt <= r_wcnt + 1'b1;
        r_acc  <= w_final ? '0 : w_sum;
      end
    end
  end

  assign fb_out = r_fb;

  // Stage: finished samples go straight into the buffer on the final tick
  sound_in_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_final),
    .i_din     (w_sample),
    .i_pop     (sample_rd),
    .i_clr_ovr (clr_ovr),
    .o_dout    (dout),
    .o_ready   (ready),
    .o_overrun (overrun)
  );

endmodule

// File: tb/tb_sound_in.sv
// Directed bench for sound_in at default parameters; buffer depth follows SND_IN_FIFO_EN.
module tb_sound_in;
`ifdef SND_IN_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pdm_in = 1'b0;
  logic       fb_out;
  logic       sample_rd = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] dout;
  logic       ready;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  sound_in #(.DIV(8), .WIN_LOG2(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .fb_out    (fb_out),
    .sample_rd (sample_rd),
    .clr_ovr   (clr_ovr),
    .dout      (dout),
    .ready     (ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One 256-tick window: pdm_in high for the first `ones` ticks; optional strobes on the final clk.
  task automatic run_window(input int ones, input bit rd_last, input bit clr_last);
    for (int t = 1; t <= 256; t++) begin
      pdm_in = (t <= ones);
      if (t == 256) begin
        repeat (7) @(posedge clk);
        #1;
        sample_rd = rd_last;
        clr_ovr   = clr_last;
        @(posedge clk);
        #1;
        sample_rd = 1'b0;
        clr_ovr   = 1'b0;
      end else begin
        repeat (8) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_rd();
    sample_rd = 1'b1;
    @(posedge clk);
    #1;
    sample_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_fb;

    // Reset state
    rst = 1'b1;
    #12;
    check("reset_ready", ready, 0);
    check("reset_dout", dout, 8'h00);
    check("reset_overrun", overrun, 0);
    check("reset_fb", fb_out, 0);

    // 1: constant ones -> 8'hFF, ready rises right after the 256th tick
    pdm_in = 1'b1;
    do_reset();
    repeat (2047) @(posedge clk);
    #1;
    check("ones_ready_early", ready, 0);
    @(posedge clk);
    #1;
    check("ones_ready", ready, 1);
    check("ones_dout", dout, 8'hFF);
    check("ones_fb", fb_out, 1);
    check("ones_overrun", overrun, 0);
    pulse_rd();
    check("ones_pop_empty", ready, 0);
    check("ones_dout_hold", dout, 8'hFF);
    pulse_rd();
    check("ones_rd_on_empty", dout, 8'hFF);

    // 2: constant zeros -> 8'h00, feedback never rises
    pdm_in = 1'b0;
    do_reset();
    seen_fb = 1'b0;
    for (int i = 1; i <= 2048; i++) begin
      @(posedge clk);
      #1;
      if (fb_out) seen_fb = 1'b1;
    end
    check("zeros_ready", ready, 1);
    check("zeros_dout", dout, 8'h00);
    check("zeros_fb_never", seen_fb, 0);

    // 3: alternate every tick -> 128 ones -> 8'h80
    pdm_in = 1'b0;
    do_reset();
    for (int i = 1; i <= 2048; i++) begin
      @(posedge clk);
      #1;
      if (i % 8 == 0) pdm_in = ~pdm_in;
    end
    check("alt_ready", ready, 1);
    check("alt_dout", dout, 8'h80);

    // 4: no reads for DEPTH+1 windows -> overrun, first DEPTH samples read back in order
    do_reset();
    for (int k = 0; k < DEPTH; k++) run_window(10 * (k + 1), 1'b0, 1'b0);
    check("fill_overrun_clear", overrun, 0);
    check("fill_head", dout, 10);
    run_window(10 * (DEPTH + 1), 1'b0, 1'b0);
    check("fill_overrun_set", overrun, 1);
    for (int k = 0; k < DEPTH; k++) begin
      check("fill_rd_ready", ready, 1);
      check("fill_rd_data", dout, 10 * (k + 1));
      pulse_rd();
    end
    check("fill_drained", ready, 0);

    // 5: pop on the push clk of a full buffer; clr_ovr loses to an overrun event
    do_reset();
    for (int k = 0; k < DEPTH; k++) run_window(11 * (k + 1), 1'b0, 1'b0);
    run_window(11 * (DEPTH + 1), 1'b1, 1'b0);
    check("pushpop_overrun", overrun, 0);
    check("pushpop_head", dout, 22);
    run_window(99, 1'b0, 1'b1);
    check("clr_vs_set", overrun, 1);
    check("clr_vs_set_head", dout, 22);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("clr_alone", overrun, 0);
    for (int k = 0; k < DEPTH; k++) begin
      check("pushpop_rd_ready", ready, 1);
      check("pushpop_rd_data", dout, 11 * (k + 2));
      pulse_rd();
    end
    check("pushpop_drained", ready, 0);

    // 6: reset at tick 100 of an all-ones window clears everything immediately
    do_reset();
    run_window(256, 1'b0, 1'b0);
    repeat (800) @(posedge clk);
    #1;
    check("midrst_pre_ready", ready, 1);
    check("midrst_pre_fb", fb_out, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 0);
    check("midrst_dout", dout, 8'h00);
    check("midrst_fb", fb_out, 0);
    check("midrst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2047) @(posedge clk);
    #1;
    check("postrst_not_early", ready, 0);
    @(posedge clk);
    #1;
    check("postrst_ready", ready, 1);
    check("postrst_dout", dout, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
